branch_sequencer: RTL and testbench

Multi-cycle control-word generator for the branch class: CBZ, CBNZ, B.cond, B and, optionally, BL. It owns its own state register and handshake, unlike the single-cycle per-instruction decoders. It drives the 31-bit datapath control word and the K constant, and it resolves branch-taken from the status flags. It sits between the instruction register and the datapath, and the top-level decoder hands it every branch-class instruction.

---
 rtl/branch_sequencer_if.sv | 49 ++++
 rtl/branch_sequencer.sv | 259 +++++++++++++++++++++++++
 tb/tb_branch_sequencer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/branch_sequencer_if.sv
// Interface bundling the branch sequencer's instruction/status inputs and
// its control, decision and debug-state outputs.
//   slave  : the sequencer itself
//   master : the side issuing branch instructions and consuming controls
//
// Handshake: start is a request qualifier that the sequencer samples only
// while state==IDLE (busy==0); a start seen in any other state is dropped,
// never queued. Completion is signalled by a one-cycle done pulse, with
// taken (and illegal, for bad encodings) valid only while done==1.
interface branch_sequencer_if #(
    parameter int K_WIDTH = 64
);
    logic                start;
    logic [31:0]         instruction;
    logic [3:0]          status;
    logic                busy;
    logic                done;
    logic                illegal;
    logic                taken;
    logic [30:0]         controlWord;
    logic [K_WIDTH-1:0]  K;
    logic [1:0]          state;

    modport slave (
        input  start,
        input  instruction,
        input  status,
        output busy,
        output done,
        output illegal,
        output taken,
        output controlWord,
        output K,
        output state
    );

    modport master (
        output start,
        output instruction,
        output status,
        input  busy,
        input  done,
        input  illegal,
        input  taken,
        input  controlWord,
        input  K,
        input  state
    );
endinterface

// File: rtl/branch_sequencer.sv
// Multi-cycle control-word generator for the branch class (CBZ, CBNZ,
// B.cond, B and optionally BL). It latches a branch instruction, walks a
// small FSM, drives the datapath control word and K offset, and resolves
// the branch-taken decision from the status flags.
//
// Build option: define BRANCH_LINK_EN to support BL through a LINK state
// that writes PC+4 into X30. Without it BL is reported as illegal and the
// LINK encoding (2'b10) is never produced.
//
// Control word layout (bit 30 down to 0):
//   {Psel[1:0], DA[4:0], SA[4:0], SB[4:0], Fsel[4:0],
//    regW, ramW, EN_MEM, EN_ALU, EN_B, EN_PC, Bsel, PCsel, SL}
module branch_sequencer #(
    parameter int K_WIDTH     = 64,
    parameter int TEST_CYCLES = 1
) (
    input  logic               clock,
    input  logic               reset_n,
    branch_sequencer_if.slave  bus
);

    // FSM encodings, also exported on bus.state for observation
    localparam logic [1:0] S_IDLE    = 2'b00;
    localparam logic [1:0] S_TEST    = 2'b01;
    localparam logic [1:0] S_LINK    = 2'b10;
    localparam logic [1:0] S_RESOLVE = 2'b11;

    // Branch kind latched on accept; BL shares KIND_B (imm26, always taken)
    localparam logic [1:0] KIND_CBZ   = 2'd0;
    localparam logic [1:0] KIND_CBNZ  = 2'd1;
    localparam logic [1:0] KIND_BCOND = 2'd2;
    localparam logic [1:0] KIND_B     = 2'd3;

    // Counter preload: TEST lasts cnt+1 cycles, so load TEST_CYCLES-1
    localparam logic [3:0] CNT_INIT = 4'(TEST_CYCLES - 1);

    // ALU OR function used to pass Rt through for the zero test
    localparam logic [4:0] FSEL_OR = 5'b00100;
    localparam logic [4:0] REG_XZR = 5'd31;
    localparam logic [4:0] REG_LR  = 5'd30;

    logic [1:0]  state_q,   state_d;
    logic [31:0] instr_q,   instr_d;
    logic [3:0]  flags_q,   flags_d;
    logic [1:0]  kind_q,    kind_d;
    logic [3:0]  cnt_q,     cnt_d;
    logic        z_q,       z_d;
    logic        illegal_q, illegal_d;

    logic is_cbz;
    logic is_cbnz;
    logic is_bcond;
    logic is_b;
`ifdef BRANCH_LINK_EN
    logic is_bl;
`endif

    logic                flag_n, flag_z, flag_c, flag_v;
    logic [3:0]          cond;
    logic                cond_base;
    logic                bcond_taken;
    logic                taken_c;
    logic                busy_c;
    logic [K_WIDTH-1:0]  imm19_ext;
    logic [K_WIDTH-1:0]  imm26_ext;

    // Control word fields, assembled into bus.controlWord below
    logic [1:0] cw_psel;
    logic [4:0] cw_da;
    logic [4:0] cw_sa;
    logic [4:0] cw_sb;
    logic [4:0] cw_fsel;
    logic       cw_regw;
    logic       cw_en_pc;
    logic       cw_pcsel;

    // Opcode decode of the incoming instruction (only used on accept)
    always_comb begin
        is_cbz   = (bus.instruction[30:24] == 7'b0110100);
        is_cbnz  = (bus.instruction[30:24] == 7'b0110101);
        is_bcond = (bus.instruction[31:24] == 8'b01010100) && !bus.instruction[4];
        is_b     = (bus.instruction[31:26] == 6'b000101);
`ifdef BRANCH_LINK_EN
        is_bl    = (bus.instruction[31:26] == 6'b100101);
`endif
    end

    // Next-state logic: accept/decode in IDLE, settle counter in TEST
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        flags_d   = flags_q;
        kind_d    = kind_q;
        cnt_d     = cnt_q;
        z_d       = z_q;
        illegal_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    instr_d = bus.instruction;
                    flags_d = bus.status;
                    if (is_cbz || is_cbnz) begin
                        kind_d  = is_cbz ? KIND_CBZ : KIND_CBNZ;
                        cnt_d   = CNT_INIT;
                        state_d = S_TEST;
                    end else if (is_bcond) begin
                        kind_d  = KIND_BCOND;
                        state_d = S_RESOLVE;
                    end else if (is_b) begin
                        kind_d  = KIND_B;
                        state_d = S_RESOLVE;
`ifdef BRANCH_LINK_EN
                    end else if (is_bl) begin
                        kind_d  = KIND_B;
                        state_d = S_LINK;
`endif
                    end else begin
                        // Unsupported encoding: report and stay idle
                        illegal_d = 1'b1;
                    end
                end
            end
            S_TEST: begin
                if (cnt_q == 4'd0) begin
                    // ALU output has settled; the zero flag reflects Rt
                    z_d     = bus.status[1];
                    state_d = S_RESOLVE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_LINK: begin
`ifdef BRANCH_LINK_EN
                state_d = S_RESOLVE;
`else
                state_d = S_IDLE;
`endif
            end
            S_RESOLVE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and latched operands; reset aborts any branch in flight
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            instr_q   <= 32'd0;
            flags_q   <= 4'd0;
            kind_q    <= KIND_CBZ;
            cnt_q     <= 4'd0;
            z_q       <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            flags_q   <= flags_d;
            kind_q    <= kind_d;
            cnt_q     <= cnt_d;
            z_q       <= z_d;
            illegal_q <= illegal_d;
        end
    end

    // Condition evaluation for B.cond from the flags latched on accept
    always_comb begin
        flag_n = flags_q[0];
        flag_z = flags_q[1];
        flag_c = flags_q[2];
        flag_v = flags_q[3];
        cond   = instr_q[3:0];
        case (cond[3:1])
            3'b000:  cond_base = flag_z;
            3'b001:  cond_base = flag_c;
            3'b010:  cond_base = flag_n;
            3'b011:  cond_base = flag_v;
            3'b100:  cond_base = flag_c & ~flag_z;
            3'b101:  cond_base = (flag_n == flag_v);
            3'b110:  cond_base = ~flag_z & (flag_n == flag_v);
            default: cond_base = 1'b1;
        endcase
        // cond=1111 is "always" too, so it must not be inverted
        if (cond == 4'b1111) begin
            bcond_taken = 1'b1;
        end else begin
            bcond_taken = cond_base ^ cond[0];
        end
    end

    // Branch decision per kind; Z for CB* comes from the TEST capture
    always_comb begin
        case (kind_q)
            KIND_CBZ:   taken_c = z_q;
            KIND_CBNZ:  taken_c = ~z_q;
            KIND_BCOND: taken_c = bcond_taken;
            default:    taken_c = 1'b1;
        endcase
    end

    // Control word fields per state; IDLE is an all-zero NOP holding PC
    always_comb begin
        cw_psel  = 2'b00;
        cw_da    = 5'd0;
        cw_sa    = 5'd0;
        cw_sb    = 5'd0;
        cw_fsel  = 5'd0;
        cw_regw  = 1'b0;
        cw_en_pc = 1'b0;
        cw_pcsel = 1'b0;
        case (state_q)
            S_TEST: begin
                cw_sa   = REG_XZR;
                cw_sb   = instr_q[4:0];
                cw_fsel = FSEL_OR;
            end
`ifdef BRANCH_LINK_EN
            S_LINK: begin
                // Return address PC+4 goes onto the bus and into X30
                cw_da    = REG_LR;
                cw_regw  = 1'b1;
                cw_en_pc = 1'b1;
            end
`endif
            S_RESOLVE: begin
                cw_psel  = {taken_c, 1'b1};
                cw_da    = REG_XZR;
                cw_sa    = REG_XZR;
                cw_sb    = ((kind_q == KIND_CBZ) || (kind_q == KIND_CBNZ)) ?
                           instr_q[4:0] : REG_XZR;
                cw_pcsel = 1'b1;
            end
            default: begin
                cw_psel = 2'b00;
            end
        endcase
    end

    // Sign-extended word offsets for the two immediate formats
    assign imm19_ext = {{(K_WIDTH - 19){instr_q[23]}}, instr_q[23:5]};
    assign imm26_ext = {{(K_WIDTH - 26){instr_q[25]}}, instr_q[25:0]};

    assign busy_c = (state_q != S_IDLE);

    assign bus.state       = state_q;
    assign bus.busy        = busy_c;
    assign bus.done        = (state_q == S_RESOLVE) || illegal_q;
    assign bus.illegal     = illegal_q;
    assign bus.taken       = (state_q == S_RESOLVE) && taken_c;
    assign bus.K           = !busy_c ? '0 :
                             (kind_q == KIND_B) ? imm26_ext : imm19_ext;
    assign bus.controlWord = {cw_psel, cw_da, cw_sa, cw_sb, cw_fsel,
                              cw_regw, 1'b0, 1'b0, 1'b0, 1'b0,
                              cw_en_pc, 1'b0, cw_pcsel, 1'b0};

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed testbench for branch_sequencer. Two instances share clock and
// reset: u_dut1 with TEST_CYCLES=1 and u_dut3 with TEST_CYCLES=3.
// Inputs change on the falling edge; outputs are checked on the falling
// edge, half a cycle away from the active rising edge.
module tb_branch_sequencer;

    logic clock;
    logic reset_n;
    int   total;
    int   bad;

    branch_sequencer_if #(.K_WIDTH(64)) bus1 ();
    branch_sequencer_if #(.K_WIDTH(64)) bus3 ();

    branch_sequencer #(.K_WIDTH(64), .TEST_CYCLES(1)) u_dut1 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    branch_sequencer #(.K_WIDTH(64), .TEST_CYCLES(3)) u_dut3 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus3)
    );

    // Clock generation
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Watchdog bound on the whole run
    initial begin
        #100000;
        $display("FAIL watchdog: sim time exceeded, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // Expected control word built from individual fields
    function automatic logic [30:0] cw_f(input logic [1:0] psel, input logic [4:0] da,
                                         input logic [4:0] sa, input logic [4:0] sb,
                                         input logic [4:0] fsel, input logic regw,
                                         input logic en_pc, input logic pcsel);
        return {psel, da, sa, sb, fsel, regw, 4'b0000, en_pc, 1'b0, pcsel, 1'b0};
    endfunction

    // Present an instruction to u_dut1 for one rising edge
    task automatic issue1(input logic [31:0] instr, input logic [3:0] st);
        bus1.start       = 1'b1;
        bus1.instruction = instr;
        bus1.status      = st;
        @(negedge clock);
        bus1.start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus1.start = 1'b0; bus1.instruction = 32'd0; bus1.status = 4'd0;
        bus3.start = 1'b0; bus3.instruction = 32'd0; bus3.status = 4'd0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        total++; if (bus1.state !== 2'b00) begin bad++; $display("FAIL reset_state: got %b expected 00", bus1.state); end
        total++; if ({bus1.busy, bus1.done, bus1.illegal, bus1.taken} !== 4'b0000) begin bad++; $display("FAIL reset_flags: got %b expected 0000", {bus1.busy, bus1.done, bus1.illegal, bus1.taken}); end
        total++; if (bus1.controlWord !== 31'd0) begin bad++; $display("FAIL reset_cw: got %h expected 0", bus1.controlWord); end
        total++; if (bus1.K !== 64'd0) begin bad++; $display("FAIL reset_k: got %h expected 0", bus1.K); end
        total++; if ({bus3.state, bus3.busy, bus3.controlWord} !== 34'd0) begin bad++; $display("FAIL reset_dut3: got %h expected 0", {bus3.state, bus3.busy, bus3.controlWord}); end
    endtask

    task automatic test_cbz();
        issue1(32'hB4000103, 4'b0000);
        bus1.status = 4'b0010;
        total++; if (bus1.state !== 2'b01) begin bad++; $display("FAIL cbz_test_state: got %b expected 01", bus1.state); end
        total++; if (bus1.controlWord !== cw_f(2'b00, 5'd0, 5'd31, 5'd3, 5'b00100, 1'b0, 1'b0, 1'b0)) begin bad++; $display("FAIL cbz_test_cw: got %h expected %h", bus1.controlWord, cw_f(2'b00, 5'd0, 5'd31, 5'd3, 5'b00100, 1'b0, 1'b0, 1'b0)); end
        total++; if (bus1.K !== 64'd8) begin bad++; $display("FAIL cbz_test_k: got %h expected 8", bus1.K); end
        @(negedge clock);
        total++; if ({bus1.state, bus1.done, bus1.taken, bus1.illegal} !== 5'b11110) begin bad++; $display("FAIL cbz_resolve_flags: got %b expected 11110", {bus1.state, bus1.done, bus1.taken, bus1.illegal}); end
        total++; if (bus1.controlWord !== cw_f(2'b11, 5'd31, 5'd31, 5'd3, 5'd0, 1'b0, 1'b0, 1'b1)) begin bad++; $display("FAIL cbz_resolve_cw: got %h expected %h", bus1.controlWord, cw_f(2'b11, 5'd31, 5'd31, 5'd3, 5'd0, 1'b0, 1'b0, 1'b1)); end
        total++; if (bus1.K !== 64'd8) begin bad++; $display("FAIL cbz_resolve_k: got %h expected 8", bus1.K); end
        @(negedge clock);
        total++; if ({bus1.state, bus1.busy, bus1.done, bus1.controlWord, bus1.K} !== 99'd0) begin bad++; $display("FAIL cbz_back_idle: got state=%b busy=%b cw=%h k=%h expected all 0", bus1.state, bus1.busy, bus1.controlWord, bus1.K); end
    endtask

    task automatic test_cbnz();
        issue1(32'hB5000103, 4'b0000);
        bus1.status = 4'b0010;
        @(negedge clock);
        total++; if (bus1.taken !== 1'b0 || bus1.done !== 1'b1) begin bad++; $display("FAIL cbnz_z1_taken: got taken=%b done=%b expected 0,1", bus1.taken, bus1.done); end
        total++; if (bus1.controlWord !== cw_f(2'b01, 5'd31, 5'd31, 5'd3, 5'd0, 1'b0, 1'b0, 1'b1)) begin bad++; $display("FAIL cbnz_z1_cw: got %h expected %h", bus1.controlWord, cw_f(2'b01, 5'd31, 5'd31, 5'd3, 5'd0, 1'b0, 1'b0, 1'b1)); end
        @(negedge clock);
        issue1(32'hB5000103, 4'b0010);
        bus1.status = 4'b0000;
        @(negedge clock);
        total++; if (bus1.taken !== 1'b1) begin bad++; $display("FAIL cbnz_z0_taken: got %b expected 1", bus1.taken); end
        total++; if (bus1.controlWord[30:29] !== 2'b11) begin bad++; $display("FAIL cbnz_z0_psel: got %b expected 11", bus1.controlWord[30:29]); end
        @(negedge clock);
    endtask

    task automatic test_test_cycles();
        int n;
        n = 0;
        bus3.start = 1'b1; bus3.instruction = 32'hB4000103; bus3.status = 4'b0000;
        @(negedge clock);
        bus3.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus3.state !== 2'b01) break;
            total++; if (bus3.busy !== 1'b1) begin bad++; $display("FAIL tc3_busy: got %b expected 1", bus3.busy); end
            n++;
            @(negedge clock);
        end
        total++; if (n !== 3) begin bad++; $display("FAIL tc3_count: got %0d expected 3", n); end
        total++; if ({bus3.state, bus3.done, bus3.taken} !== 4'b1110) begin bad++; $display("FAIL tc3_resolve: got %b expected 1110", {bus3.state, bus3.done, bus3.taken}); end
        @(negedge clock);
        total++; if (bus3.busy !== 1'b0) begin bad++; $display("FAIL tc3_idle: got %b expected 0", bus3.busy); end
    endtask

    task automatic test_immediates();
        issue1(32'hB4FFFFE3, 4'b0000);
        total++; if (bus1.K !== {64{1'b1}}) begin bad++; $display("FAIL k_neg1: got %h expected ffffffffffffffff", bus1.K); end
        @(negedge clock);
        total++; if (bus1.taken !== 1'b0) begin bad++; $display("FAIL k_neg1_taken: got %b expected 0", bus1.taken); end
        @(negedge clock);
        issue1(32'h14000010, 4'b0000);
        total++; if ({bus1.state, bus1.done, bus1.taken} !== 4'b1111) begin bad++; $display("FAIL b_resolve: got %b expected 1111", {bus1.state, bus1.done, bus1.taken}); end
        total++; if (bus1.K !== 64'd16) begin bad++; $display("FAIL b_k: got %h expected 10", bus1.K); end
        total++; if (bus1.controlWord !== cw_f(2'b11, 5'd31, 5'd31, 5'd31, 5'd0, 1'b0, 1'b0, 1'b1)) begin bad++; $display("FAIL b_cw: got %h expected %h", bus1.controlWord, cw_f(2'b11, 5'd31, 5'd31, 5'd31, 5'd0, 1'b0, 1'b0, 1'b1)); end
        @(negedge clock);
        total++; if (bus1.busy !== 1'b0) begin bad++; $display("FAIL b_two_cycles: got busy=%b expected 0", bus1.busy); end
    endtask

    task automatic test_bcond();
        logic [31:0] instrs [6];
        logic [3:0]  flags  [6];
        logic        exp_t  [6];
        // B.NE Z=0, B.NE Z=1, B.GE N=V=1, B.GE N=1 V=0, cond=1111, B.EQ Z=0
        instrs = '{32'h54000101, 32'h54000101, 32'h5400010A, 32'h5400010A, 32'h5400010F, 32'h54000100};
        flags  = '{4'b0000, 4'b0010, 4'b1001, 4'b0001, 4'b0000, 4'b0000};
        exp_t  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            issue1(instrs[i], flags[i]);
            // Live flags change after accept; the decision must use the latched ones
            bus1.status = ~flags[i];
            total++; if (bus1.taken !== exp_t[i] || bus1.done !== 1'b1) begin bad++; $display("FAIL bcond_%0d: got taken=%b done=%b expected %b,1", i, bus1.taken, bus1.done, exp_t[i]); end
            total++; if (bus1.controlWord[30:29] !== {exp_t[i], 1'b1} || bus1.K !== 64'd8) begin bad++; $display("FAIL bcond_%0d_psel_k: got %b/%h expected %b/8", i, bus1.controlWord[30:29], bus1.K, {exp_t[i], 1'b1}); end
            @(negedge clock);
        end
    endtask

    task automatic test_bl();
        issue1(32'h94000010, 4'b0000);
`ifdef BRANCH_LINK_EN
        total++; if (bus1.state !== 2'b10) begin bad++; $display("FAIL bl_link_state: got %b expected 10", bus1.state); end
        total++; if (bus1.controlWord !== cw_f(2'b00, 5'd30, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0)) begin bad++; $display("FAIL bl_link_cw: got %h expected %h", bus1.controlWord, cw_f(2'b00, 5'd30, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0)); end
        @(negedge clock);
        total++; if ({bus1.state, bus1.done, bus1.taken} !== 4'b1111 || bus1.K !== 64'd16) begin bad++; $display("FAIL bl_resolve: got %b k=%h expected 1111 k=10", {bus1.state, bus1.done, bus1.taken}, bus1.K); end
`else
        total++; if ({bus1.state, bus1.busy, bus1.done, bus1.illegal, bus1.taken} !== 6'b000110) begin bad++; $display("FAIL bl_illegal: got %b expected 000110", {bus1.state, bus1.busy, bus1.done, bus1.illegal, bus1.taken}); end
        total++; if (bus1.controlWord[8] !== 1'b0) begin bad++; $display("FAIL bl_no_regw: got %b expected 0", bus1.controlWord[8]); end
`endif
        @(negedge clock);
        total++; if (bus1.busy !== 1'b0 || bus1.done !== 1'b0) begin bad++; $display("FAIL bl_after: got busy=%b done=%b expected 0,0", bus1.busy, bus1.done); end
    endtask

    task automatic test_reset_mid();
        issue1(32'hB4000103, 4'b0000);
        reset_n = 1'b0;
        #1;
        total++; if (bus1.controlWord !== 31'd0 || bus1.busy !== 1'b0 || bus1.state !== 2'b00) begin bad++; $display("FAIL reset_mid: got cw=%h busy=%b state=%b expected 0", bus1.controlWord, bus1.busy, bus1.state); end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        total++; if (bus1.busy !== 1'b0 || bus1.done !== 1'b0) begin bad++; $display("FAIL reset_mid_after: got busy=%b done=%b expected 0,0", bus1.busy, bus1.done); end
    endtask

    task automatic test_start_while_busy();
        issue1(32'hB4000103, 4'b0000);
        bus1.status = 4'b0010;
        bus1.start = 1'b1; bus1.instruction = 32'h14000010;
        @(negedge clock);
        total++; if (bus1.controlWord !== cw_f(2'b11, 5'd31, 5'd31, 5'd3, 5'd0, 1'b0, 1'b0, 1'b1) || bus1.K !== 64'd8) begin bad++; $display("FAIL busy_start_resolve: got cw=%h k=%h expected %h k=8", bus1.controlWord, bus1.K, cw_f(2'b11, 5'd31, 5'd31, 5'd3, 5'd0, 1'b0, 1'b0, 1'b1)); end
        bus1.start = 1'b0;
        @(negedge clock);
        total++; if (bus1.busy !== 1'b0) begin bad++; $display("FAIL busy_start_dropped: got busy=%b expected 0", bus1.busy); end
    endtask

    task automatic test_illegal();
        issue1(32'hFFFFFFFF, 4'b0000);
        total++; if ({bus1.state, bus1.busy, bus1.done, bus1.illegal, bus1.taken} !== 6'b000110) begin bad++; $display("FAIL illegal_pulse: got %b expected 000110", {bus1.state, bus1.busy, bus1.done, bus1.illegal, bus1.taken}); end
        total++; if (bus1.controlWord !== 31'd0) begin bad++; $display("FAIL illegal_cw: got %h expected 0", bus1.controlWord); end
        @(negedge clock);
        total++; if (bus1.done !== 1'b0 || bus1.illegal !== 1'b0) begin bad++; $display("FAIL illegal_one_cycle: got done=%b illegal=%b expected 0,0", bus1.done, bus1.illegal); end
    endtask

    task automatic test_back_to_back();
        issue1(32'h14000010, 4'b0000);
        total++; if (bus1.done !== 1'b1 || bus1.K !== 64'd16) begin bad++; $display("FAIL b2b_first: got done=%b k=%h expected 1 k=10", bus1.done, bus1.K); end
        @(negedge clock);
        total++; if (bus1.state !== 2'b00) begin bad++; $display("FAIL b2b_gap: got %b expected 00", bus1.state); end
        issue1(32'h54000101, 4'b0000);
        total++; if (bus1.done !== 1'b1 || bus1.taken !== 1'b1 || bus1.K !== 64'd8) begin bad++; $display("FAIL b2b_second: got done=%b taken=%b k=%h expected 1,1 k=8", bus1.done, bus1.taken, bus1.K); end
        @(negedge clock);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_cbz();
        test_cbnz();
        test_test_cycles();
        test_immediates();
        test_bcond();
        test_bl();
        test_reset_mid();
        test_start_while_busy();
        test_illegal();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
